// File: rtl/seven_seg_scan_capture_if.sv
// Pin-side and result-side signals of the seven-segment scan capture block.
// The master side drives the display pins; the slave side is the capture logic.
interface seven_seg_scan_capture_if;
    logic [6:0]  seg_in;
    logic [5:0]  an_in;
    logic [41:0] seg_out;
    logic [23:0] hex_out;
    logic [5:0]  hex_ok;
    logic        frame_done;
    logic        stale;

    modport master (
        output seg_in, an_in,
        input  seg_out, hex_out, hex_ok, frame_done, stale
    );

    modport slave (
        input  seg_in, an_in,
        output seg_out, hex_out, hex_ok, frame_done, stale
    );
endinterface

// File: rtl/seven_seg_scan_capture.sv
// Demultiplexes a scanned six-digit seven-segment bus into held digit registers,
// decodes each pattern to hex, and flags completed frames and stalled scanning.
module seven_seg_scan_capture #(
    parameter int SETTLE_CYCLES = 16,
    parameter int TIMEOUT       = 1000000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    seven_seg_scan_capture_if.slave   bus
);
    localparam int CW = (SETTLE_CYCLES > 2) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_END = CW'(SETTLE_CYCLES - 1);
    localparam logic [TW-1:0] TO_MAX  = TW'(TIMEOUT);

    logic [12:0]   sync1_reg, sync2_reg, prev_reg;
    logic [CW-1:0] cnt_reg;
    logic          armed_reg;
    logic [5:0]    mask_reg;
    logic [TW-1:0] to_cnt_reg;
    logic          stale_reg;
    logic [6:0]    seg_reg [6];
    logic [3:0]    hex_reg [6];
    logic [5:0]    hex_ok_reg;

    logic [5:0]    s_an, sel, mask_next;
    logic [6:0]    s_seg;
    logic          stable, dwell_end, one_sel, capture, frame_done;
    logic [3:0]    dec_hex;
    logic          dec_ok;
    logic [TW-1:0] to_cnt_next;

    function automatic logic [4:0] decode(input logic [6:0] p);
        case (p)
            7'h40: decode = {1'b1, 4'h0};
            7'h79: decode = {1'b1, 4'h1};
            7'h24: decode = {1'b1, 4'h2};
            7'h30: decode = {1'b1, 4'h3};
            7'h19: decode = {1'b1, 4'h4};
            7'h12: decode = {1'b1, 4'h5};
            7'h02: decode = {1'b1, 4'h6};
            7'h78: decode = {1'b1, 4'h7};
            7'h00: decode = {1'b1, 4'h8};
            7'h10: decode = {1'b1, 4'h9};
            7'h08: decode = {1'b1, 4'hA};
            7'h03: decode = {1'b1, 4'hB};
            7'h46: decode = {1'b1, 4'hC};
            7'h21: decode = {1'b1, 4'hD};
            7'h06: decode = {1'b1, 4'hE};
            7'h0E: decode = {1'b1, 4'hF};
            default: decode = 5'b0;
        endcase
    endfunction

    always_comb begin
        s_an      = sync2_reg[12:7];
        s_seg     = sync2_reg[6:0];
        stable    = (sync2_reg == prev_reg);
        dwell_end = stable && (cnt_reg == CNT_END) && armed_reg;
        sel       = ~s_an;
        // Exactly one anode low: sel is non-zero and a power of two.
        one_sel   = (sel != 6'd0) && ((sel & (sel - 6'd1)) == 6'd0);
        capture   = dwell_end && one_sel;
        {dec_ok, dec_hex} = decode(s_seg);
        mask_next = mask_reg | (capture ? sel : 6'd0);
        frame_done = capture && (mask_next == 6'h3F);
        if (capture)
            to_cnt_next = '0;
        else if (to_cnt_reg == TO_MAX)
            to_cnt_next = TO_MAX;
        else
            to_cnt_next = to_cnt_reg + TW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_reg  <= '0;
            sync2_reg  <= '0;
            prev_reg   <= '0;
            cnt_reg    <= '0;
            armed_reg  <= 1'b0;
            mask_reg   <= '0;
            to_cnt_reg <= '0;
            stale_reg  <= 1'b0;
            hex_ok_reg <= '0;
            for (int i = 0; i < 6; i++) begin
                seg_reg[i] <= 7'h7F;
                hex_reg[i] <= 4'h0;
            end
        end else begin
            sync1_reg <= {bus.an_in, bus.seg_in};
            sync2_reg <= sync1_reg;
            prev_reg  <= sync2_reg;
            if (!stable) begin
                cnt_reg   <= '0;
                armed_reg <= 1'b1;
            end else begin
                if (cnt_reg != CNT_END)
                    cnt_reg <= cnt_reg + CW'(1);
                // Disarm at dwell end even for bad anode codes so no late capture follows.
                if (dwell_end)
                    armed_reg <= 1'b0;
            end
            mask_reg   <= frame_done ? 6'd0 : mask_next;
            to_cnt_reg <= to_cnt_next;
            stale_reg  <= (to_cnt_next == TO_MAX);
            if (capture) begin
                for (int i = 0; i < 6; i++) begin
                    if (sel[i]) begin
                        seg_reg[i]    <= s_seg;
                        hex_reg[i]    <= dec_hex;
                        hex_ok_reg[i] <= dec_ok;
                    end
                end
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 6; gi++) begin : g_out
            assign bus.seg_out[7*gi +: 7] = seg_reg[gi];
            assign bus.hex_out[4*gi +: 4] = hex_reg[gi];
        end
    endgenerate

    assign bus.hex_ok     = hex_ok_reg;
    assign bus.frame_done = frame_done;
    assign bus.stale      = stale_reg;
endmodule

// File: tb/tb_seven_seg_scan_capture.sv
// Directed and randomized dwell-level checking of seven_seg_scan_capture against
// a reference model that reasons about whole pin dwells rather than cycles.
module tb_seven_seg_scan_capture;
    localparam int S = 16;
    localparam int T = 200;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    seven_seg_scan_capture_if bus();

    seven_seg_scan_capture #(.SETTLE_CYCLES(S), .TIMEOUT(T)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [6:0] pat [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    logic [6:0]  m_seg [6];
    logic [3:0]  m_hex [6];
    logic [5:0]  m_ok;
    logic [5:0]  m_mask;
    int          since;
    logic [12:0] last_pins;
    int          checks = 0;
    int          fails  = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 6; i++) begin
            m_seg[i] = 7'h7F;
            m_hex[i] = 4'h0;
        end
        m_ok   = 6'd0;
        m_mask = 6'd0;
        since  = 0;
    endtask

    function automatic logic [41:0] exp_seg();
        logic [41:0] v;
        for (int i = 0; i < 6; i++) v[7*i +: 7] = m_seg[i];
        return v;
    endfunction

    function automatic logic [23:0] exp_hex();
        logic [23:0] v;
        for (int i = 0; i < 6; i++) v[4*i +: 4] = m_hex[i];
        return v;
    endfunction

    // Hold one pin value for n cycles; a dwell long enough to settle captures once.
    task automatic dwell(input logic [5:0] an, input logic [6:0] seg, input int n, input string tag);
        int zeros, k, pulses, pulse_at;
        logic cap, frame, ok;
        logic [3:0] h;
        logic [5:0] new_mask;
        bus.an_in  = an;
        bus.seg_in = seg;
        last_pins  = {an, seg};
        zeros = 0;
        k = 0;
        for (int b = 0; b < 6; b++) if (!an[b]) begin zeros++; k = b; end
        cap = (n >= S + 3) && (zeros == 1);
        h = 4'h0;
        ok = 1'b0;
        for (int p = 0; p < 16; p++) if (pat[p] == seg) begin h = 4'(p); ok = 1'b1; end
        new_mask = m_mask | (cap ? (6'd1 << k) : 6'd0);
        frame = cap && (new_mask == 6'h3F);
        pulses = 0;
        pulse_at = -1;
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            since++;
            if (cap && i == S + 3) begin
                since = 0;
                m_seg[k] = seg;
                m_hex[k] = h;
                m_ok[k]  = ok;
                m_mask   = frame ? 6'd0 : new_mask;
            end
            chk({tag, "_stale"}, 64'(bus.stale), 64'(since >= T));
            if (bus.frame_done === 1'b1) begin
                pulses++;
                pulse_at = i;
            end
        end
        chk({tag, "_frame_cnt"}, 64'(pulses), 64'(frame ? 1 : 0));
        if (frame) chk({tag, "_frame_at"}, 64'(pulse_at), 64'(S + 2));
        chk({tag, "_seg_out"}, 64'(bus.seg_out), 64'(exp_seg()));
        chk({tag, "_hex_out"}, 64'(bus.hex_out), 64'(exp_hex()));
        chk({tag, "_hex_ok"},  64'(bus.hex_ok),  64'(m_ok));
        $display("dwell %-8s an=%b seg=%h n=%0d capture=%0d frame=%0d hex_out=%h", tag, an, seg, n, cap, frame, bus.hex_out);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_seg_out"}, 64'(bus.seg_out), 64'({6{7'h7F}}));
        chk({tag, "_hex_out"}, 64'(bus.hex_out), 64'd0);
        chk({tag, "_hex_ok"},  64'(bus.hex_ok),  64'd0);
        chk({tag, "_frame"},   64'(bus.frame_done), 64'd0);
        chk({tag, "_stale"},   64'(bus.stale), 64'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] an;
        logic [6:0] seg;
        int n;
        bus.an_in  = 6'h3F;
        bus.seg_in = 7'h7F;
        model_reset();
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst_n = 1'b1;
        since = 0;

        // Full frame of digits 0..5.
        dwell(6'b111110, 7'h40, 40, "t1_d0");
        dwell(6'b111101, 7'h79, 40, "t1_d1");
        dwell(6'b111011, 7'h24, 40, "t1_d2");
        dwell(6'b110111, 7'h30, 40, "t1_d3");
        dwell(6'b101111, 7'h19, 40, "t1_d4");
        dwell(6'b011111, 7'h12, 40, "t1_d5");
        chk("t1_hex_const", 64'(bus.hex_out), 64'h543210);
        chk("t1_ok_const",  64'(bus.hex_ok),  64'h3F);

        // Short glitch followed by a settled value.
        dwell(6'b111110, 7'h79, 10, "t2_glit");
        dwell(6'b111110, 7'h24, 40, "t2_good");
        chk("t2_d0_const", 64'(bus.hex_out[3:0]), 64'h2);

        // Invalid anode codes leave everything untouched.
        dwell(6'b111100, 7'h24, 100, "t3_two");
        dwell(6'b111111, 7'h24, 100, "t3_none");

        // Unknown pattern still stored and counted.
        dwell(6'b111011, 7'h7F, 40, "t4_blank");
        chk("t4_raw_const", 64'(bus.seg_out[20:14]), 64'h7F);
        chk("t4_ok_const",  64'(bus.hex_ok[2]), 64'd0);

        // Stale after scanning stops, cleared by the next capture.
        dwell(6'b111110, 7'h40, 40, "t5_cap");
        dwell(6'b111111, 7'h7F, 250, "t5_idle");
        chk("t5_stale_const", 64'(bus.stale), 64'd1);
        dwell(6'b111101, 7'h79, 40, "t5_resume");

        // Asynchronous reset mid-frame.
        dwell(6'b111110, 7'h40, 40, "t6_d0");
        dwell(6'b111101, 7'h79, 40, "t6_d1");
        dwell(6'b111011, 7'h24, 40, "t6_d2");
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("t6_rst");
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        dwell(6'b110111, 7'h30, 40, "t6_d3");
        dwell(6'b101111, 7'h19, 40, "t6_d4");
        dwell(6'b011111, 7'h12, 40, "t6_d5");
        dwell(6'b111110, 7'h02, 40, "t6_d0b");
        dwell(6'b111101, 7'h78, 40, "t6_d1b");
        dwell(6'b111011, 7'h00, 40, "t6_d2b");

        // Randomized dwells.
        for (int r = 0; r < 60; r++) begin
            if ($urandom_range(0, 4) != 0) begin
                an = ~(6'd1 << $urandom_range(0, 5));
            end else if ($urandom_range(0, 1) == 0) begin
                an = 6'h3F;
            end else begin
                an = 6'h3F;
                an[$urandom_range(0, 2)] = 1'b0;
                an[$urandom_range(3, 5)] = 1'b0;
            end
            if ($urandom_range(0, 9) < 7) seg = pat[$urandom_range(0, 15)];
            else seg = 7'($urandom);
            if ({an, seg} == last_pins) seg = seg ^ 7'h01;
            if ($urandom_range(0, 9) < 3) n = $urandom_range(2, S);
            else n = $urandom_range(S + 3, 60);
            dwell(an, seg, n, "rand");
        end

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule

// File: doc/seven_seg_scan_capture.md
Name: seven_seg_scan_capture

Overview:
- Receive-side counterpart of the six-digit multiplexed seven-segment driver.
- Samples the time-multiplexed segment bus and active-low anode lines, demultiplexes them into six held digit registers, and decodes each pattern to a hex nibble.
- Flags each completed frame and flags a stale display when scanning stops.
- Used for board-level loopback checking of display output and for reading external multiplexed displays.

Parameters:
SETTLE_CYCLES, 16, consecutive identical synchronized samples required before a capture; must be >= 2.
TIMEOUT, 1000000, cycles without any capture before stale asserts.

Ports:
clk  input  1  system clock
rst_n  input  1  reset; asynchronous, active-low
seg_in  input  7  segment bus, bit6..0 = g..a, active-low (0 = lit)
an_in  input  6  anode selects, active-low; bit k low selects digit k
seg_out  output  42  captured raw pattern; digit k at [7k+6:7k]
hex_out  output  24  decoded value; digit k at [4k+3:4k]
hex_ok  output  6  bit k = 1 when digit k's pattern matched the decode table
frame_done  output  1  one-cycle pulse when all six digits have been captured since the last pulse
stale  output  1  high when no capture has occurred for TIMEOUT cycles

Behaviour:
- Reset, asynchronous: seg_out all 7'h7F per digit, hex_out 0, hex_ok 0, frame_done 0, stale 0. All internal state to 0: synchronizers, prev sample, settle counter, armed, capture mask, timeout counter.
- Reset asserted mid-operation aborts everything immediately. After release, the block rebuilds its state from fresh samples only.
- Input path: {an_in, seg_in} pass through a 2-flop synchronizer to give sample s. A prev register holds s from the previous cycle.
- Settle logic:
  - s != prev: cnt <= 0, armed <= 1.
  - s == prev and cnt < SETTLE_CYCLES-1: cnt increments.
  - cnt saturates at SETTLE_CYCLES-1.
- Capture condition: s == prev, cnt == SETTLE_CYCLES-1, armed = 1, and the anode part of s has exactly one zero bit at k.
- On capture:
  - seg_out[k] <= segment part of s.
  - hex_out[k] and hex_ok[k] from the decode table.
  - mask[k] <= 1, armed <= 0, timeout counter <= 0.
  - Exactly one capture per stable dwell.
- Invalid anode codes (all ones, or two or more zeros): never captured. armed still clears at count end, so no late capture occurs.
- Latency: outputs update 2+SETTLE_CYCLES cycles after a pin change that is then held stable.
- Decode table (g..a, hex value):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
  - Any other pattern: hex nibble 0, hex_ok[k] 0, raw pattern still stored in seg_out.
- Re-capture of a digit already in mask overwrites its registers; the mask bit stays set.
- Frame logic: when the next mask value equals 6'h3F, frame_done = 1 for exactly that one cycle and mask clears to 0 on the same edge.
- Stale logic:
  - Timeout counter increments each cycle without a capture and saturates at TIMEOUT.
  - stale = (counter == TIMEOUT), registered.
  - stale clears on the edge following a capture.
  - The counter is sized clog2(TIMEOUT+1).
- Simultaneous events: a capture in the same cycle the counter would reach TIMEOUT wins, so stale stays 0.

Test Plan:
1. SETTLE=16. Drive six dwells of 40 cycles each: an=111110..011111 with seg=40,79,24,30,19,12. Expect hex_out=24'h543210, hex_ok=6'h3F, one frame_done pulse 18 cycles after the digit-5 dwell starts, no other pulses.
2. Glitch: an=111110, seg=79 held 10 cycles, then seg=24 held 40 cycles. Expect digit0 captures only 24 (hex 2). The value 79 is never captured.
3. Invalid anodes: 111100 then 111111, each held 100 cycles. Expect seg_out, hex_out, hex_ok, and mask unchanged, and no frame_done.
4. Unknown/blank: digit2 with seg=7F held 40 cycles. Expect seg_out[20:14]=7F, hex_out[11:8]=0, hex_ok[2]=0. Digit2 still counts toward frame completion.
5. Stale: TIMEOUT=200, stop scanning after one capture. Expect stale=1 exactly 200 cycles after that capture edge. Resume scanning; stale=0 the cycle after the next capture.
6. Reset mid-frame: after capturing digits 0-2, pulse rst_n low for 3 cycles asynchronously. Expect all outputs at reset values immediately. Capturing digits 3-5 alone then produces no frame_done.
